// File: rtl/lcd_arbiter.sv
// lcd_arbiter: HD44780 4-bit init sequencer with round-robin arbitration of two byte requesters
module lcd_arbiter #(
    parameter int E_HIGH_CYC = 12,
    parameter int SHORT_CYC  = 2000,
    parameter int LONG_CYC   = 80000,
    parameter int PWRUP_CYC  = 800000
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [3:0] lcd_dq,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic       init_done,
    output logic       busy
);
    localparam int MAX_A = E_HIGH_CYC > SHORT_CYC ? E_HIGH_CYC : SHORT_CYC;
    localparam int MAX_B = LONG_CYC > PWRUP_CYC ? LONG_CYC : PWRUP_CYC;
    localparam int MAX_C = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int CW = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] E_LAST = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] S_LAST = CW'(SHORT_CYC - 1);
    localparam logic [CW-1:0] L_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] P_LAST = CW'(PWRUP_CYC - 1);

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, EHIGH, HOLD, NGAP, BGAP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    step_q;
    logic [7:0]    byte_q;
    logic          rs_q;
    logic          single_q;
    logic          lo_q;
    logic          last_q;
    logic          init_done_q;
    logic          lcd_e_q;
    logic          lcd_rs_q;
    logic [3:0]    lcd_dq_q;

    logic          grant0;
    logic          grant1;
    logic [7:0]    sel_data;
    logic          sel_rs;
    logic          long_gap;
    logic [CW-1:0] gap_last;
    logic [7:0]    nxt_init;

    // Init items 0..3 are single nibbles (kept in the high half), 4..7 full command bytes
    function automatic logic [7:0] init_tab(input logic [2:0] s);
        return s < 3'd3 ? 8'h30 : s == 3'd3 ? 8'h20 : s == 3'd4 ? 8'h28 :
               s == 3'd5 ? 8'h0C : s == 3'd6 ? 8'h01 : 8'h06;
    endfunction

    assign grant0   = state_q == IDLE && init_done_q && req0_valid && (!req1_valid || last_q);
    assign grant1   = state_q == IDLE && init_done_q && req1_valid && (!req0_valid || !last_q);
    assign sel_data = grant0 ? req0_data : req1_data;
    assign sel_rs   = grant0 ? req0_rs : req1_rs;
    assign long_gap = (!init_done_q && step_q == 3'd0) ||
                      (!rs_q && !single_q && byte_q inside {8'h01, 8'h02, 8'h03});
    assign gap_last = long_gap ? L_LAST : S_LAST;
    assign nxt_init = init_tab(step_q + 3'd1);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign lcd_dq     = lcd_dq_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_e      = lcd_e_q;
    assign init_done  = init_done_q;
    assign busy       = state_q != IDLE;

    // Sequencer: data/RS only change on entry to INIT/SETUP, where E is already low
    always_ff @(posedge refclk) begin
        if (reset) begin
            state_q     <= PWRUP;
            cnt_q       <= '0;
            step_q      <= '0;
            byte_q      <= '0;
            rs_q        <= 1'b0;
            single_q    <= 1'b0;
            lo_q        <= 1'b0;
            last_q      <= 1'b1;
            init_done_q <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_dq_q    <= '0;
        end else begin
            case (state_q)
                PWRUP: begin
                    if (cnt_q == P_LAST) begin
                        cnt_q    <= '0;
                        byte_q   <= 8'h30;
                        single_q <= 1'b1;
                        rs_q     <= 1'b0;
                        lo_q     <= 1'b0;
                        lcd_rs_q <= 1'b0;
                        lcd_dq_q <= 4'h3;
                        state_q  <= INIT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                INIT, SETUP: begin
                    lcd_e_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= EHIGH;
                end
                EHIGH: begin
                    if (cnt_q == E_LAST) begin
                        cnt_q   <= '0;
                        lcd_e_q <= 1'b0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    cnt_q   <= '0;
                    state_q <= (single_q || lo_q) ? BGAP : NGAP;
                end
                NGAP: begin
                    if (cnt_q == E_LAST) begin
                        cnt_q    <= '0;
                        lo_q     <= 1'b1;
                        lcd_dq_q <= byte_q[3:0];
                        state_q  <= SETUP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                BGAP: begin
                    if (cnt_q == gap_last) begin
                        cnt_q <= '0;
                        lo_q  <= 1'b0;
                        if (init_done_q || step_q == 3'd7) begin
                            init_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            step_q   <= step_q + 3'd1;
                            byte_q   <= nxt_init;
                            single_q <= step_q < 3'd3;
                            lcd_dq_q <= nxt_init[7:4];
                            state_q  <= INIT;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                IDLE: begin
                    if (grant0 || grant1) begin
                        byte_q   <= sel_data;
                        rs_q     <= sel_rs;
                        single_q <= 1'b0;
                        lo_q     <= 1'b0;
                        last_q   <= grant1;
                        lcd_rs_q <= sel_rs;
                        lcd_dq_q <= sel_data[7:4];
                        state_q  <= SETUP;
                    end
                end
                default: state_q <= PWRUP;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_arbiter.sv
// tb_lcd_arbiter: directed checks of init timing, byte strobes, gaps, arbitration and reset
module tb_lcd_arbiter;
    logic       refclk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready, lcd_rs, lcd_e, init_done, busy;
    logic [3:0] lcd_dq;

    lcd_arbiter #(.E_HIGH_CYC(2), .SHORT_CYC(4), .LONG_CYC(10), .PWRUP_CYC(20)) dut (
        .refclk(refclk), .reset(reset),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .lcd_dq(lcd_dq), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .init_done(init_done), .busy(busy)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    int errors = 0, checks = 0;
    int rc[256], rd[256], rr[256], hw[256];
    int nr = 0;
    int gc[64], gi[64];
    int ng = 0, both = 0, e_viol = 0;
    logic pe = 1'b0, prs = 1'b0;
    logic [3:0] pdq = 4'h0;

    // Count rising edges so cyc equals the index of the most recent edge
    always @(posedge refclk) cyc <= cyc + 1;

    // Log E strobes, E-high widths, grants and protocol violations mid-cycle
    always @(negedge refclk) begin
        #2;
        if (lcd_e && !pe && nr < 256) begin
            rc[nr] = cyc;
            rd[nr] = int'(lcd_dq);
            rr[nr] = int'(lcd_rs);
            nr++;
        end
        if (!lcd_e && pe && nr > 0) hw[nr-1] = cyc - rc[nr-1];
        if (lcd_e && pe && (lcd_dq !== pdq || lcd_rs !== prs)) e_viol++;
        if (req0_ready && req1_ready) both++;
        if (req0_ready && ng < 64) begin gc[ng] = cyc; gi[ng] = 0; ng++; end
        if (req1_ready && ng < 64) begin gc[ng] = cyc; gi[ng] = 1; ng++; end
        pe = lcd_e;
        pdq = lcd_dq;
        prs = lcd_rs;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic wait_idle(output int c);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge refclk);
            if (!busy) begin
                c = cyc;
                break;
            end
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    task automatic check_init(input int r, input int b);
        int off[12] = '{21, 35, 43, 51, 59, 65, 73, 79, 87, 93, 107, 113};
        int nib[12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 1, 0, 6};
        for (int i = 0; i < 400; i++) begin
            @(negedge refclk);
            if (init_done) break;
        end
        chk("init_done_cyc", cyc - r, 120);
        chk("busy_after_init", int'(busy), 0);
        #3;
        chk("init_strobes", nr - b, 12);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("init_dq%0d", k), rd[b+k], nib[k]);
            chk($sformatf("init_t%0d", k), rc[b+k] - r, off[k]);
            chk($sformatf("init_rs%0d", k), rr[b+k], 0);
            chk($sformatf("init_ew%0d", k), hw[b+k], 2);
        end
    endtask

    task automatic send(input int id, input logic rs, input logic [7:0] d, output int c0, output int ce);
        @(negedge refclk);
        if (id == 0) begin req0_valid = 1'b1; req0_rs = rs; req0_data = d; end
        else begin req1_valid = 1'b1; req1_rs = rs; req1_data = d; end
        #1;
        c0 = cyc;
        chk("ready_sel", int'(id == 0 ? req0_ready : req1_ready), 1);
        chk("ready_other", int'(id == 0 ? req1_ready : req0_ready), 0);
        @(negedge refclk);
        chk("ready_one_cycle", int'(id == 0 ? req0_ready : req1_ready), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle(ce);
        #3;
    endtask

    initial begin
        int r, b, gb, c0, ce, i0, i1;
        bit p0, p1, fin;
        logic [7:0] exp_b;
        reset = 1'b1;
        repeat (3) @(negedge refclk);
        #3;
        chk("rst_lcd_e", int'(lcd_e), 0);
        chk("rst_lcd_rs", int'(lcd_rs), 0);
        chk("rst_lcd_dq", int'(lcd_dq), 0);
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_ready1", int'(req1_ready), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_busy", int'(busy), 1);
        r = cyc;
        b = nr;
        reset = 1'b0;
        check_init(r, b);

        b = nr;
        send(0, 1'b1, 8'h41, c0, ce);
        chk("b41_strobes", nr - b, 2);
        chk("b41_hi", rd[b], 4);
        chk("b41_lo", rd[b+1], 1);
        chk("b41_rs_hi", rr[b], 1);
        chk("b41_rs_lo", rr[b+1], 1);
        chk("b41_t_hi", rc[b] - c0, 2);
        chk("b41_t_lo", rc[b+1] - c0, 8);
        chk("b41_ew_hi", hw[b], 2);
        chk("b41_ew_lo", hw[b+1], 2);
        chk("b41_idle", ce - c0, 15);

        b = nr;
        send(1, 1'b0, 8'h01, c0, ce);
        chk("clr_idle_long", ce - c0, 21);
        chk("clr_rs", rr[b], 0);
        chk("clr_hi", rd[b], 0);
        chk("clr_lo", rd[b+1], 1);
        send(1, 1'b1, 8'h01, c0, ce);
        chk("data01_idle_short", ce - c0, 15);

        b = nr;
        gb = ng;
        i0 = 0; i1 = 0; p0 = 0; p1 = 0; fin = 0;
        @(negedge refclk);
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h61;
        for (int t = 0; t < 400; t++) begin
            #1;
            if (req0_ready) p0 = 1;
            if (req1_ready) p1 = 1;
            @(negedge refclk);
            if (p0) begin
                p0 = 0; i0++;
                if (i0 == 4) req0_valid = 1'b0; else req0_data = 8'(8'h41 + i0);
            end
            if (p1) begin
                p1 = 0; i1++;
                if (i1 == 4) req1_valid = 1'b0; else req1_data = 8'(8'h61 + i1);
            end
            if (i0 == 4 && i1 == 4 && !busy) begin
                fin = 1;
                break;
            end
        end
        #3;
        chk("rr_done", int'(fin), 1);
        chk("rr_grants", ng - gb, 8);
        chk("rr_strobes", nr - b, 16);
        for (int k = 0; k < 8; k++) begin
            exp_b = (k % 2 == 0) ? 8'(8'h41 + k / 2) : 8'(8'h61 + k / 2);
            chk($sformatf("rr_who%0d", k), gi[gb+k], k % 2);
            chk($sformatf("rr_hi%0d", k), rd[b+2*k], int'(exp_b[7:4]));
            chk($sformatf("rr_lo%0d", k), rd[b+2*k+1], int'(exp_b[3:0]));
        end

        @(negedge refclk);
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        #1;
        chk("mid_ready", int'(req0_ready), 1);
        @(negedge refclk);
        req0_valid = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (lcd_e) break;
            @(negedge refclk);
        end
        chk("mid_e_high", int'(lcd_e), 1);
        reset = 1'b1;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
        @(negedge refclk);
        #1;
        chk("mid_rst_e", int'(lcd_e), 0);
        chk("mid_rst_init_done", int'(init_done), 0);
        chk("mid_rst_busy", int'(busy), 1);
        chk("mid_rst_ready", int'(req0_ready), 0);
        r = cyc;
        b = nr;
        gb = ng;
        reset = 1'b0;
        check_init(r, b);
        chk("pwr_grants", ng - gb, 1);
        chk("pwr_grant_t", gc[gb] - r, 120);
        chk("pwr_grant_who", gi[gb], 0);
        @(negedge refclk);
        req0_valid = 1'b0;
        wait_idle(ce);
        #3;
        chk("pwr_idle", ce - r, 135);
        chk("pwr_strobes", nr - b, 14);
        chk("pwr_hi", rd[b+12], 5);
        chk("pwr_lo", rd[b+13], 5);

        chk("never_both_ready", both, 0);
        chk("e_stable", e_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 SHALL have parameter E_HIGH_CYC, default 12: number of cycles lcd_e is held high per nibble strobe.
REQ-002 SHALL have parameter SHORT_CYC, default 2000: gap in cycles after a normal byte or init nibble (≥37 us).
REQ-003 SHALL have parameter LONG_CYC, default 80000: gap in cycles after clear/home commands and after the first init nibble (≥4.1 ms).
REQ-004 SHALL have parameter PWRUP_CYC, default 800000: wait in cycles from reset release to the first init nibble (≥15 ms).
REQ-005 refclk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req0_valid  in  1  requester 0 (POST decoder) has a byte pending.
REQ-008 req0_rs  in  1  requester 0 register select (0=command, 1=data).
REQ-009 req0_data  in  8  requester 0 byte.
REQ-010 req0_ready  out  1  one-cycle accept strobe to requester 0.
REQ-011 req1_valid, req1_rs, req1_data[7:0], req1_ready  same widths and meaning for requester 1 (status/banner).
REQ-012 lcd_dq  out  4  HD44780 D7..D4.
REQ-013 lcd_rs  out  1  HD44780 RS.
REQ-014 lcd_e  out  1  HD44780 E.
REQ-015 init_done  out  1  high once the init sequence has completed.
REQ-016 busy  out  1  high whenever the block is not in IDLE.

Function
REQ-017 States SHALL be: PWRUP, INIT, IDLE, SETUP, EHIGH, HOLD, NGAP, BGAP.
REQ-018 PWRUP SHALL count PWRUP_CYC cycles, then enter INIT.
REQ-019 INIT SHALL emit, RS=0, single nibbles 0x3, 0x3, 0x3, 0x2, then bytes 0x28, 0x0C, 0x01, 0x06; gaps: LONG_CYC after the first 0x3 and after 0x01, SHORT_CYC after all others; then init_done=1 and enter IDLE.
REQ-020 A nibble strobe SHALL be: SETUP 1 cycle (lcd_dq/lcd_rs driven, lcd_e=0), EHIGH E_HIGH_CYC cycles (lcd_e=1), HOLD 1 cycle (lcd_e=0, lcd_dq/lcd_rs unchanged).
REQ-021 A byte SHALL be sent as high nibble, NGAP of E_HIGH_CYC cycles, then low nibble, then BGAP.
REQ-022 BGAP length SHALL be LONG_CYC if RS=0 and data is 0x01, 0x02 or 0x03; otherwise SHORT_CYC.
REQ-023 req*_ready SHALL assert only in IDLE with init_done=1, for exactly one cycle, to the selected requester with valid=1; the byte and RS are latched in that cycle and SETUP begins next cycle.
REQ-024 Requesters SHALL hold valid/rs/data stable until ready; valid deasserted before ready drops the request without effect.
REQ-025 Arbitration SHALL be round-robin: a single pending requester wins; if both pending, the one not granted last wins; last-grant resets to 1 so requester 0 wins the first tie.
REQ-026 At most one ready SHALL be asserted in any cycle; no requester is granted twice in a row while the other is continuously pending.
REQ-027 Requests presented during PWRUP/INIT or any non-IDLE state SHALL wait; none is lost or reordered within a requester.
REQ-028 lcd_e SHALL never be high in any cycle where lcd_dq or lcd_rs changes.
REQ-029 All counters SHALL be wide enough for the largest parameter; no wrap occurs within a state.

Reset
REQ-030 On reset=1 at a clock edge: state=PWRUP, counters=0, lcd_e=0, lcd_rs=0, lcd_dq=0x0, req0_ready=req1_ready=0, init_done=0, busy=1, last-grant=1.
REQ-031 Reset asserted mid-strobe SHALL drive lcd_e=0 at the next edge and abandon the in-flight byte; the full init sequence reruns after release.

Verification (parameters E_HIGH_CYC=2, SHORT_CYC=4, LONG_CYC=10, PWRUP_CYC=20)
REQ-032 Reset release -> lcd_e first rises 21 cycles later (1 SETUP cycle after 20 PWRUP cycles) with lcd_dq=0x3, lcd_rs=0; the full strobe sequence is 3,3,3,2,2,8,0,C,0,1,0,6; the 0x3→0x3 gap after the first nibble is 10 cycles; init_done rises after the final 4-cycle gap.
REQ-033 After init, req0 sends rs=1 data 0x41 -> req0_ready pulses 1 cycle; nibbles 0x4 then 0x1 with lcd_rs=1; lcd_e high 2 cycles each; next ready possible after the 4-cycle BGAP.
REQ-034 req0 and req1 both held valid from the same cycle, 4 bytes each -> grants alternate 0,1,0,1,...; exactly 8 ready pulses, never simultaneous.
REQ-035 req1 sends rs=0 data 0x01 -> BGAP of 10 cycles before busy drops; the same byte with rs=1 -> BGAP of 4 cycles.
REQ-036 Reset pulsed while lcd_e=1 mid-byte -> lcd_e=0 at the next edge, init_done=0, and the init sequence from REQ-032 repeats exactly.
REQ-037 req0_valid raised during PWRUP -> no ready until init_done=1; then ready in the first IDLE cycle.
